// File: rtl/mac_feeder_pkg.sv
// Shared types and default sizing for the MAC feeder and its environment.
package mac_feeder_pkg;

   localparam int N_ATTR  = 5;
   localparam int DATA_W  = 8;
   localparam int RES_W   = 16;
   localparam int MAC_LAT = 1;

   typedef enum logic [1:0] {
      COEF = 2'd0,
      ATTR = 2'd1,
      WAIT = 2'd2,
      OUT  = 2'd3
   } state_t;

endpackage

// File: rtl/mac_feeder_if.sv
// Byte stream into the feeder plus the result handshake out of it.
interface mac_feeder_if #(
   parameter int DATA_W = mac_feeder_pkg::DATA_W,
   parameter int RES_W  = mac_feeder_pkg::RES_W
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              coef_reload;
   logic              res_valid;
   logic              res_ready;
   logic [RES_W-1:0]  res_data;

   modport master (
      output in_valid, in_data, coef_reload, res_ready,
      input  in_ready, res_valid, res_data
   );

   modport slave (
      input  in_valid, in_data, coef_reload, res_ready,
      output in_ready, res_valid, res_data
   );
endinterface

// File: rtl/mac_feeder.sv
// Collects 5 coefficient then 5 attribute bytes into registers for an external MAC and hands off its result.
// Result valid MAC_LAT+2 cycles after the fifth attribute; input stalls (in_ready=0) until the result is taken.
module mac_feeder #(
   parameter int N_ATTR  = mac_feeder_pkg::N_ATTR,
   parameter int DATA_W  = mac_feeder_pkg::DATA_W,
   parameter int RES_W   = mac_feeder_pkg::RES_W,
   parameter int MAC_LAT = mac_feeder_pkg::MAC_LAT
) (
   input  logic              clk,
   input  logic              rst_n,
   mac_feeder_if.slave       bus,
   output logic [DATA_W-1:0] mac_a1,
   output logic [DATA_W-1:0] mac_a2,
   output logic [DATA_W-1:0] mac_a3,
   output logic [DATA_W-1:0] mac_a4,
   output logic [DATA_W-1:0] mac_a5,
   output logic [DATA_W-1:0] mac_c1,
   output logic [DATA_W-1:0] mac_c2,
   output logic [DATA_W-1:0] mac_c3,
   output logic [DATA_W-1:0] mac_c4,
   output logic [DATA_W-1:0] mac_c5,
   input  logic [RES_W-1:0]  mac_out,
   output logic [15:0]       res_count
);
   import mac_feeder_pkg::*;

   localparam int IDX_W  = $clog2(N_ATTR);
   localparam int WCNT_W = $clog2(MAC_LAT + 2) + 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_ATTR - 1);
   localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(MAC_LAT + 1);

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [WCNT_W-1:0]  wcnt;
   logic [DATA_W-1:0]  a_q [N_ATTR];
   logic [DATA_W-1:0]  c_q [N_ATTR];
   logic               in_ready_q;
   logic               res_valid_q;
   logic [RES_W-1:0]   res_data_q;
   logic [15:0]        res_count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= COEF;
         idx         <= '0;
         wcnt        <= '0;
         in_ready_q  <= 1'b1;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_count_q <= '0;
         for (int i = 0; i < N_ATTR; i++) begin
            a_q[i] <= '0;
            c_q[i] <= '0;
         end
      end else begin
         case (state)
            COEF: begin
               if (bus.in_valid && in_ready_q) begin
                  for (int i = 0; i < N_ATTR; i++)
                     if (idx == IDX_W'(i)) c_q[i] <= bus.in_data;
                  if (idx == LAST_IDX) begin
                     idx   <= '0;
                     state <= ATTR;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            ATTR: begin
               // A reload wins over a byte offered in the same cycle; that byte stays unconsumed.
               if (bus.coef_reload) begin
                  idx   <= '0;
                  state <= COEF;
               end else if (bus.in_valid && in_ready_q) begin
                  for (int i = 0; i < N_ATTR; i++)
                     if (idx == IDX_W'(i)) a_q[i] <= bus.in_data;
                  if (idx == LAST_IDX) begin
                     idx        <= '0;
                     wcnt       <= WAIT_LOAD;
                     in_ready_q <= 1'b0;
                     state      <= WAIT;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            WAIT: begin
               if (wcnt == WCNT_W'(1)) begin
                  res_data_q  <= mac_out;
                  res_valid_q <= 1'b1;
                  state       <= OUT;
               end else begin
                  wcnt <= wcnt - 1'b1;
               end
            end
            OUT: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  res_count_q <= res_count_q + 16'd1;
                  in_ready_q  <= 1'b1;
                  state       <= ATTR;
               end
            end
            default: begin
               state       <= COEF;
               idx         <= '0;
               in_ready_q  <= 1'b1;
               res_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign res_count     = res_count_q;

   assign mac_a1 = a_q[0];
   assign mac_a2 = a_q[1];
   assign mac_a3 = a_q[2];
   assign mac_a4 = a_q[3];
   assign mac_a5 = a_q[4];
   assign mac_c1 = c_q[0];
   assign mac_c2 = c_q[1];
   assign mac_c3 = c_q[2];
   assign mac_c4 = c_q[3];
   assign mac_c5 = c_q[4];

endmodule
